// File: rtl/store_rmw_controller_if.sv
// Store request and data-memory port bundle for store_rmw_controller.
// master = pipeline + memory side, slave = the controller.
interface store_rmw_controller_if #(
   parameter int unsigned MEM_ADDR_W = 10
) ();
   logic                  req_valid;
   logic                  req_ready;
   logic [31:0]           req_addr;
   logic [31:0]           req_wdata;
   logic [2:0]            req_funct3;
   logic                  mem_rd_en;
   logic [MEM_ADDR_W-1:0] mem_addr;
   logic [31:0]           mem_rdata;
   logic                  mem_wr_en;
   logic [31:0]           mem_wdata;
   logic                  done;
   logic                  store_err;

   modport master (
      output req_valid, req_addr, req_wdata, req_funct3, mem_rdata,
      input  req_ready, mem_rd_en, mem_addr, mem_wr_en, mem_wdata, done, store_err
   );

   modport slave (
      input  req_valid, req_addr, req_wdata, req_funct3, mem_rdata,
      output req_ready, mem_rd_en, mem_addr, mem_wr_en, mem_wdata, done, store_err
   );
endinterface

// File: rtl/store_rmw_controller.sv
// MEM-stage store sequencer: word stores write directly, byte/half stores
// do read-merge-write on the single-port synchronous data memory.
module store_rmw_controller #(
   parameter int unsigned MEM_ADDR_W = 10
) (
   input logic                   clk,
   input logic                   reset,
   store_rmw_controller_if.slave bus
);

   typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, ERR} state_t;

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;

   state_t                state, state_nxt;
   logic                  half_q, half_nxt;
   logic [1:0]            off_q, off_nxt;
   logic [15:0]           data_q, data_nxt;
   logic                  rd_en_q, rd_en_nxt;
   logic                  wr_en_q, wr_en_nxt;
   logic                  done_q, done_nxt;
   logic                  err_q, err_nxt;
   logic [MEM_ADDR_W-1:0] addr_q, addr_nxt;
   logic [31:0]           wdata_q, wdata_nxt;
   logic [31:0]           merged_c;
   logic [1:0]            req_off_c;
   logic                  unused_addr_bits;

   assign req_off_c        = bus.req_addr[1:0];
   assign unused_addr_bits = ^bus.req_addr[31:MEM_ADDR_W+2];

   // Lane merge of the latched store data into the word read back from memory.
   always_comb begin
      merged_c = bus.mem_rdata;
      unique case ({half_q, off_q})
         3'b000:  merged_c = {bus.mem_rdata[31:8], data_q[7:0]};
         3'b001:  merged_c = {bus.mem_rdata[31:16], data_q[7:0], bus.mem_rdata[7:0]};
         3'b010:  merged_c = {bus.mem_rdata[31:24], data_q[7:0], bus.mem_rdata[15:0]};
         3'b011:  merged_c = {data_q[7:0], bus.mem_rdata[23:0]};
         3'b100:  merged_c = {bus.mem_rdata[31:16], data_q[15:0]};
         3'b110:  merged_c = {data_q[15:0], bus.mem_rdata[15:0]};
         default: merged_c = bus.mem_rdata;
      endcase
   end

   // Next state plus next value of every registered output.
   always_comb begin
      state_nxt = state;
      half_nxt  = half_q;
      off_nxt   = off_q;
      data_nxt  = data_q;
      addr_nxt  = addr_q;
      wdata_nxt = wdata_q;
      rd_en_nxt = 1'b0;
      wr_en_nxt = 1'b0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.req_valid) begin
               half_nxt = (bus.req_funct3 == F3_SH);
               off_nxt  = req_off_c;
               data_nxt = bus.req_wdata[15:0];
               addr_nxt = bus.req_addr[MEM_ADDR_W+1:2];
               if (bus.req_funct3 == F3_SW && req_off_c == 2'b00) begin
                  state_nxt = WRITE;
                  wdata_nxt = bus.req_wdata;
                  wr_en_nxt = 1'b1;
                  done_nxt  = 1'b1;
               end else if (bus.req_funct3 == F3_SB ||
                            (bus.req_funct3 == F3_SH && !req_off_c[0])) begin
                  state_nxt = READ;
                  rd_en_nxt = 1'b1;
               end else begin
                  state_nxt = ERR;
                  err_nxt   = 1'b1;
                  done_nxt  = 1'b1;
               end
            end
         end
         READ:  state_nxt = MERGE;
         MERGE: begin
            state_nxt = WRITE;
            wdata_nxt = merged_c;
            wr_en_nxt = 1'b1;
            done_nxt  = 1'b1;
         end
         WRITE:   state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         half_q  <= 1'b0;
         off_q   <= 2'b00;
         data_q  <= 16'h0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         rd_en_q <= 1'b0;
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         half_q  <= half_nxt;
         off_q   <= off_nxt;
         data_q  <= data_nxt;
         addr_q  <= addr_nxt;
         wdata_q <= wdata_nxt;
         rd_en_q <= rd_en_nxt;
         wr_en_q <= wr_en_nxt;
         done_q  <= done_nxt;
         err_q   <= err_nxt;
      end
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.mem_rd_en = rd_en_q;
   assign bus.mem_wr_en = wr_en_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.done      = done_q;
   assign bus.store_err = err_q;

endmodule

// File: tb/tb_store_rmw_controller.sv
// Randomized bench for store_rmw_controller against a byte-lane memory model.
module tb_store_rmw_controller;

   localparam int unsigned AW = 10;

   logic clk = 1'b0;
   logic reset;

   store_rmw_controller_if #(.MEM_ADDR_W(AW)) bus ();

   store_rmw_controller #(.MEM_ADDR_W(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [31:0]   mem     [0:(1<<AW)-1];
   logic [31:0]   ref_mem [0:(1<<AW)-1];
   logic          pl_en;
   logic [AW-1:0] pl_addr;
   logic [31:0]   pl_data;
   int            wr_total;
   int            overlap_cnt;
   int            n_checks;
   int            n_fail;

   // Synchronous single-port data memory with a bench-side preload port.
   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else begin
         if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
         if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
      end
      if (bus.mem_wr_en) wr_total <= wr_total + 1;
      if (bus.mem_rd_en && bus.mem_wr_en) overlap_cnt <= overlap_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] d,
                                             input int off, input int size);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < size; i++) r[(off+i)*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      ref_mem[a] = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Issue one request at a negedge with the controller idle; observe until ready returns.
   task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
      logic [AW-1:0] idx;
      int            off, size;
      bit            ok, got_ready;
      int            rd_n, rd_cyc, wr_n, wr_cyc, done_n, done_cyc, err_n, err_cyc, rdy_cyc;
      logic [31:0]   rd_a, wr_a, wr_d, exp_word;
      int            e_rd, e_wr, e_done, e_err, e_rdy;

      idx  = a[AW+1:2];
      off  = int'(a[1:0]);
      size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
      ok   = (size != 0) && ((off % size) == 0);
      rd_n = 0; rd_cyc = 0; wr_n = 0; wr_cyc = 0; done_n = 0; done_cyc = 0;
      err_n = 0; err_cyc = 0; rdy_cyc = 0; got_ready = 1'b0;
      rd_a = 32'h0; wr_a = 32'h0; wr_d = 32'h0;

      check("ready_before_req", 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_addr   = a;
      bus.req_wdata  = d;
      bus.req_funct3 = f3;
      @(posedge clk);
      for (int k = 1; k <= 8 && !got_ready; k++) begin
         @(negedge clk);
         if (bus.mem_rd_en) begin rd_n++; rd_cyc = k; rd_a = 32'(bus.mem_addr); end
         if (bus.mem_wr_en) begin
            wr_n++; wr_cyc = k; wr_a = 32'(bus.mem_addr); wr_d = bus.mem_wdata;
         end
         if (bus.done)      begin done_n++; done_cyc = k; end
         if (bus.store_err) begin err_n++;  err_cyc = k;  end
         if (bus.req_ready) begin
            got_ready = 1'b1;
            rdy_cyc   = k;
         end else begin
            // Busy: junk on the request bus must be ignored.
            bus.req_valid  = 1'($urandom_range(0, 1));
            bus.req_addr   = $urandom;
            bus.req_wdata  = $urandom;
            bus.req_funct3 = 3'($urandom_range(0, 7));
         end
      end
      bus.req_valid = 1'b0;
      if (!got_ready) check("ready_timeout", 32'd0, 32'd1);

      if (!ok) begin
         e_rd = 0; e_wr = 0; e_done = 1; e_err = 1; e_rdy = 2;
         exp_word = ref_mem[idx];
      end else if (size == 4) begin
         e_rd = 0; e_wr = 1; e_done = 1; e_err = 0; e_rdy = 2;
         exp_word = d;
      end else begin
         e_rd = 1; e_wr = 3; e_done = 3; e_err = 0; e_rdy = 4;
         exp_word = ref_merge(ref_mem[idx], d, off, size);
      end
      if (ok) ref_mem[idx] = exp_word;

      check("rd_count", rd_n, (e_rd != 0) ? 1 : 0);
      check("rd_cycle", rd_cyc, e_rd);
      check("wr_count", wr_n, (e_wr != 0) ? 1 : 0);
      check("wr_cycle", wr_cyc, e_wr);
      check("done_count", done_n, 1);
      check("done_cycle", done_cyc, e_done);
      check("err_cycle", err_cyc, e_err);
      check("err_count", err_n, (e_err != 0) ? 1 : 0);
      check("ready_cycle", rdy_cyc, e_rdy);
      if (e_rd != 0) check("rd_addr", rd_a, 32'(idx));
      if (e_wr != 0) begin
         check("wr_addr", wr_a, 32'(idx));
         check("wr_data", wr_d, exp_word);
      end
      check("mem_word", mem[idx], ref_mem[idx]);
   endtask

   initial begin
      logic [31:0] a;
      logic [2:0]  f3;
      int          r, wr_before;

      n_checks = 0; n_fail = 0; wr_total = 0; overlap_cnt = 0;
      reset = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = 32'h0;
      bus.req_valid = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.req_funct3 = 3'd0;
      bus.mem_rdata = 32'h0;
      repeat (2) @(negedge clk);

      check("rst_ready", 32'(bus.req_ready), 32'd1);
      check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
      check("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_err", 32'(bus.store_err), 32'd0);
      check("rst_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_wdata", bus.mem_wdata, 32'd0);

      for (int i = 0; i < 32; i++) preload(AW'(i), $urandom);
      reset = 1'b0;

      // Directed cases on word 4.
      preload(AW'(4), 32'hAABBCCDD);
      run_req(32'h11, 32'h000000EE, 3'b000);
      check("tp_sb_off1", mem[4], 32'hAABBEEDD);
      preload(AW'(4), 32'hAABBCCDD);
      run_req(32'h13, 32'h12345655, 3'b000);
      check("tp_sb_off3", mem[4], 32'h55BBCCDD);
      preload(AW'(4), 32'hAABBCCDD);
      run_req(32'h12, 32'hFFFF1234, 3'b001);
      check("tp_sh_off2", mem[4], 32'h1234CCDD);
      preload(AW'(4), 32'hAABBCCDD);
      run_req(32'h10, 32'hFFFF1234, 3'b001);
      check("tp_sh_off0", mem[4], 32'hAABB1234);
      run_req(32'h10, 32'hDEADBEEF, 3'b010);
      check("tp_sw", mem[4], 32'hDEADBEEF);
      run_req(32'h13, 32'h11111111, 3'b001);
      run_req(32'h12, 32'h22222222, 3'b010);
      run_req(32'h10, 32'h33333333, 3'b011);
      check("tp_err_mem", mem[4], 32'hDEADBEEF);

      // Reset during MERGE of a byte store: the write must never happen.
      preload(AW'(4), 32'hAABBCCDD);
      bus.req_valid = 1'b1; bus.req_addr = 32'h11; bus.req_wdata = 32'hEE; bus.req_funct3 = 3'b000;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      wr_before = wr_total;
      reset = 1'b1;
      #1;
      check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
      check("mid_rst_strobes", 32'({bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.store_err}), 32'd0);
      check("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
      check("mid_rst_wdata", bus.mem_wdata, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_rst_no_write", wr_total, wr_before);
      check("mid_rst_mem", mem[4], 32'hAABBCCDD);

      // Random traffic, mostly back-to-back, with address bits above memory range.
      for (int n = 0; n < 300; n++) begin
         a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
         r = $urandom_range(0, 9);
         f3 = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
         run_req(a, $urandom, f3);
      end

      check("rd_wr_overlap", overlap_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
